// File: rtl/umi_regfile_pkg.sv
// rtl/umi_regfile_pkg.sv - UMI register endpoint opcodes, command field positions, error codes and FSM states
package umi_regfile_pkg;

    localparam logic [4:0] OP_READ       = 5'h01;
    localparam logic [4:0] OP_WRITE      = 5'h03;
    localparam logic [4:0] OP_POSTED     = 5'h05;
    localparam logic [4:0] OP_RESP_READ  = 5'h02;
    localparam logic [4:0] OP_RESP_WRITE = 5'h04;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 5;
    localparam int SIZE_LSB   = 5;
    localparam int SIZE_W     = 3;
    localparam int LEN_LSB    = 8;
    localparam int LEN_W      = 8;
    localparam int ERR_LSB    = 25;
    localparam int ERR_W      = 2;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_DECODE = 2'b10;
    localparam logic [1:0] ERR_UNSUP  = 2'b11;

    localparam logic [2:0] SIZE_32 = 3'd2;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/umi_regfile_decode.sv
// rtl/umi_regfile_decode.sv - combinational legality check and word index for a register access
module umi_regfile_decode
    import umi_regfile_pkg::*;
#(
    parameter int             AW    = 64,
    parameter int             CW    = 32,
    parameter int             NREGS = 8,
    parameter logic [AW-1:0]  BASE  = '0,
    parameter int             RIW   = $clog2(NREGS)
) (
    input  logic [CW-1:0]  cmd,
    input  logic [AW-1:0]  dstaddr,
    output logic           legal,
    output logic           is_status,
    output logic [RIW-1:0] index
);

    logic [AW-1:0] offset;
    logic [AW-3:0] word;

    assign offset = dstaddr - BASE;
    assign word   = offset[AW-1:2];
    assign index  = word[RIW-1:0];

    // Word NREGS aliases the read-only status register; index bits wrap to 0 there, so callers must honour is_status.
    assign is_status = (word == (AW-2)'(NREGS));

    assign legal = (cmd[SIZE_LSB +: SIZE_W] == SIZE_32) &&
                   (cmd[LEN_LSB +: LEN_W] == '0) &&
                   (dstaddr[1:0] == 2'b00) &&
                   (dstaddr >= BASE) &&
                   (word <= (AW-2)'(NREGS));

    logic unused_bits;
    assign unused_bits = ^{offset[1:0], cmd[CW-1:LEN_LSB+LEN_W], cmd[OPCODE_LSB +: OPCODE_W]};

endmodule

// File: rtl/umi_regfile.sv
// rtl/umi_regfile.sv - UMI request-terminating register bank with status word; UMI_REGFILE_POSTED_EN enables posted writes
module umi_regfile
    import umi_regfile_pkg::*;
#(
    parameter int             DW    = 256,
    parameter int             AW    = 64,
    parameter int             CW    = 32,
    parameter int             NREGS = 8,
    parameter logic [AW-1:0]  BASE  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              umi_req_valid,
    input  logic [CW-1:0]     umi_req_cmd,
    input  logic [AW-1:0]     umi_req_dstaddr,
    input  logic [AW-1:0]     umi_req_srcaddr,
    input  logic [DW-1:0]     umi_req_data,
    output logic              umi_req_ready,
    output logic              umi_resp_valid,
    output logic [CW-1:0]     umi_resp_cmd,
    output logic [AW-1:0]     umi_resp_dstaddr,
    output logic [AW-1:0]     umi_resp_srcaddr,
    output logic [DW-1:0]     umi_resp_data,
    input  logic              umi_resp_ready,
    output logic [NREGS*32-1:0] reg_q,
    input  logic [31:0]       status_i
);

    localparam int RIW = $clog2(NREGS);

    state_t         state, state_next;
    logic [31:0]    regs [NREGS];
    logic           accept;
    logic           legal, is_status;
    logic [RIW-1:0] index;
    logic [4:0]     req_opcode;

    logic           wr_en, send_resp;
    logic [4:0]     rsp_op;
    logic [1:0]     rsp_err;
    logic [31:0]    rsp_rdata;
    logic [CW-1:0]  rsp_cmd;

    umi_regfile_decode #(
        .AW    (AW),
        .CW    (CW),
        .NREGS (NREGS),
        .BASE  (BASE),
        .RIW   (RIW)
    ) u_decode (
        .cmd       (umi_req_cmd),
        .dstaddr   (umi_req_dstaddr),
        .legal     (legal),
        .is_status (is_status),
        .index     (index)
    );

    assign req_opcode     = umi_req_cmd[OPCODE_LSB +: OPCODE_W];
    assign umi_req_ready  = (state == ST_IDLE) & ~rst;
    assign umi_resp_valid = (state == ST_RESP);
    assign accept         = umi_req_valid & umi_req_ready;

    always_comb begin
        wr_en     = 1'b0;
        send_resp = 1'b1;
        rsp_op    = OP_RESP_WRITE;
        rsp_err   = ERR_UNSUP;
        rsp_rdata = '0;
        case (req_opcode)
            OP_READ: begin
                rsp_op = OP_RESP_READ;
                if (legal) begin
                    rsp_err   = ERR_OK;
                    rsp_rdata = is_status ? status_i : regs[index];
                end else begin
                    rsp_err = ERR_DECODE;
                end
            end
            OP_WRITE: begin
                if (legal && !is_status) begin
                    wr_en   = 1'b1;
                    rsp_err = ERR_OK;
                end else begin
                    rsp_err = ERR_DECODE;
                end
            end
`ifdef UMI_REGFILE_POSTED_EN
            OP_POSTED: begin
                send_resp = 1'b0;
                wr_en     = legal && !is_status;
            end
`endif
            default: ;
        endcase
        rsp_cmd = umi_req_cmd;
        rsp_cmd[OPCODE_LSB +: OPCODE_W] = rsp_op;
        rsp_cmd[ERR_LSB +: ERR_W]       = rsp_err;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && send_resp) state_next = ST_RESP;
            ST_RESP: if (umi_resp_ready)      state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Response fields load only on accept, which keeps them stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            umi_resp_cmd     <= '0;
            umi_resp_dstaddr <= '0;
            umi_resp_srcaddr <= '0;
            umi_resp_data    <= '0;
        end else if (accept && send_resp) begin
            umi_resp_cmd     <= rsp_cmd;
            umi_resp_dstaddr <= umi_req_srcaddr;
            umi_resp_srcaddr <= umi_req_dstaddr;
            umi_resp_data    <= DW'(rsp_rdata);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (accept && wr_en) begin
            regs[index] <= umi_req_data[31:0];
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = regs[g];
    end

    if (DW > 32) begin : g_unused
        logic unused_data;
        assign unused_data = ^umi_req_data[DW-1:32];
    end

endmodule

// File: tb/tb_umi_regfile.sv
// tb/tb_umi_regfile.sv - scoreboard bench for umi_regfile: directed requests, queued expected responses
module tb_umi_regfile;

    localparam int DW    = 256;
    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int NREGS = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              umi_req_valid = 1'b0;
    logic [CW-1:0]     umi_req_cmd = '0;
    logic [AW-1:0]     umi_req_dstaddr = '0;
    logic [AW-1:0]     umi_req_srcaddr = '0;
    logic [DW-1:0]     umi_req_data = '0;
    logic              umi_req_ready;
    logic              umi_resp_valid;
    logic [CW-1:0]     umi_resp_cmd;
    logic [AW-1:0]     umi_resp_dstaddr;
    logic [AW-1:0]     umi_resp_srcaddr;
    logic [DW-1:0]     umi_resp_data;
    logic              umi_resp_ready = 1'b1;
    logic [NREGS*32-1:0] reg_q;
    logic [31:0]       status_i = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  cmd;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [255:0] data;
    } exp_t;
    exp_t sb[$];

    umi_regfile #(.DW(DW), .AW(AW), .CW(CW), .NREGS(NREGS), .BASE('0)) dut (
        .clk              (clk),
        .rst              (rst),
        .umi_req_valid    (umi_req_valid),
        .umi_req_cmd      (umi_req_cmd),
        .umi_req_dstaddr  (umi_req_dstaddr),
        .umi_req_srcaddr  (umi_req_srcaddr),
        .umi_req_data     (umi_req_data),
        .umi_req_ready    (umi_req_ready),
        .umi_resp_valid   (umi_resp_valid),
        .umi_resp_cmd     (umi_resp_cmd),
        .umi_resp_dstaddr (umi_resp_dstaddr),
        .umi_resp_srcaddr (umi_resp_srcaddr),
        .umi_resp_data    (umi_resp_data),
        .umi_resp_ready   (umi_resp_ready),
        .reg_q            (reg_q),
        .status_i         (status_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request cmd with filler in the non-field bits so pass-through is observable.
    function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size, input logic [7:0] len);
        return 32'hA8A5_0000 | {16'h0, len, size, op};
    endfunction

    function automatic logic [31:0] rsp_cmd(input logic [31:0] req, input logic [4:0] op, input logic [1:0] err);
        logic [31:0] r;
        r = req;
        r[4:0]   = op;
        r[26:25] = err;
        return r;
    endfunction

    task automatic expect_resp(input logic [31:0] req, input logic [4:0] op, input logic [1:0] err,
                               input logic [63:0] dst, input logic [63:0] src, input logic [31:0] data);
        exp_t e;
        e.cmd  = rsp_cmd(req, op, err);
        e.dst  = src;
        e.src  = dst;
        e.data = {224'h0, data};
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src, input logic [31:0] wdata);
        int n = 0;
        while (!umi_req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!umi_req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        umi_req_valid   = 1'b1;
        umi_req_cmd     = cmd;
        umi_req_dstaddr = dst;
        umi_req_srcaddr = src;
        umi_req_data    = {224'hF0F0, wdata};
        @(posedge clk); #1;
        umi_req_valid   = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 256'(sb.size()), 256'd0);
    endtask

    always @(negedge clk) begin
        if (umi_resp_valid && umi_resp_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: got cmd %0h expected none", umi_resp_cmd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_cmd",     256'(umi_resp_cmd),     256'(e.cmd));
                check("resp_dstaddr", 256'(umi_resp_dstaddr), 256'(e.dst));
                check("resp_srcaddr", 256'(umi_resp_srcaddr), 256'(e.src));
                check("resp_data",    umi_resp_data,          e.data);
            end
        end
    end

    localparam logic [4:0] RD  = 5'h01, WR = 5'h03, PW = 5'h05;
    localparam logic [4:0] RRD = 5'h02, RWR = 5'h04;

    initial begin
        logic [31:0] c;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  256'(umi_req_ready),  256'd0);
        check("rst_resp_valid", 256'(umi_resp_valid), 256'd0);
        check("rst_resp_cmd",   256'(umi_resp_cmd),   256'd0);
        check("rst_resp_data",  umi_resp_data,        256'd0);
        check("rst_reg_q",      reg_q,                256'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", 256'(umi_req_ready), 256'd1);

        // Write to word 2, response must be valid the next cycle
        c = mk_cmd(WR, 3'd2, 8'd0);
        expect_resp(c, RWR, 2'b00, 64'h8, 64'h1000, 32'h0);
        issue(c, 64'h8, 64'h1000, 32'hDEADBEEF);
        check("wr_resp_latency", 256'(umi_resp_valid), 256'd1);
        check("wr_reg_q2",       256'(reg_q[95:64]),   256'(32'hDEADBEEF));
        wait_drain();

        // Read back with consumer stalled for 5 cycles
        umi_resp_ready = 1'b0;
        c = mk_cmd(RD, 3'd2, 8'd0);
        expect_resp(c, RRD, 2'b00, 64'h8, 64'h2000, 32'hDEADBEEF);
        issue(c, 64'h8, 64'h2000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",     256'(umi_resp_valid),      256'd1);
            check("stall_data",      umi_resp_data,             {224'h0, 32'hDEADBEEF});
            check("stall_req_ready", 256'(umi_req_ready),       256'd0);
            @(posedge clk); #1;
        end
        umi_resp_ready = 1'b1;
        wait_drain();

        // Status word read, write rejected, re-read
        status_i = 32'h12345678;
        c = mk_cmd(RD, 3'd2, 8'd0);
        expect_resp(c, RRD, 2'b00, 64'd32, 64'h30, 32'h12345678);
        issue(c, 64'd32, 64'h30, 32'h0);
        c = mk_cmd(WR, 3'd2, 8'd0);
        expect_resp(c, RWR, 2'b10, 64'd32, 64'h31, 32'h0);
        issue(c, 64'd32, 64'h31, 32'hFFFFFFFF);
        c = mk_cmd(RD, 3'd2, 8'd0);
        expect_resp(c, RRD, 2'b00, 64'd32, 64'h32, 32'h12345678);
        issue(c, 64'd32, 64'h32, 32'h0);
        wait_drain();
        check("status_wr_reg_q", reg_q, {160'h0, 32'hDEADBEEF, 64'h0});

        // Illegal accesses
        c = mk_cmd(RD, 3'd2, 8'd0);
        expect_resp(c, RRD, 2'b10, 64'd2, 64'h40, 32'h0);
        issue(c, 64'd2, 64'h40, 32'h0);
        c = mk_cmd(RD, 3'd2, 8'd1);
        expect_resp(c, RRD, 2'b10, 64'd8, 64'h41, 32'h0);
        issue(c, 64'd8, 64'h41, 32'h0);
        c = mk_cmd(RD, 3'd2, 8'd0);
        expect_resp(c, RRD, 2'b10, 64'd36, 64'h42, 32'h0);
        issue(c, 64'd36, 64'h42, 32'h0);
        c = mk_cmd(RD, 3'd3, 8'd0);
        expect_resp(c, RRD, 2'b10, 64'd8, 64'h43, 32'h0);
        issue(c, 64'd8, 64'h43, 32'h0);
        c = mk_cmd(WR, 3'd2, 8'd0);
        expect_resp(c, RWR, 2'b10, 64'd10, 64'h44, 32'h0);
        issue(c, 64'd10, 64'h44, 32'h55555555);
        c = mk_cmd(5'h07, 3'd2, 8'd0);
        expect_resp(c, RWR, 2'b11, 64'd4, 64'h45, 32'h0);
        issue(c, 64'd4, 64'h45, 32'h66666666);
        wait_drain();
        check("illegal_reg_q", reg_q, {160'h0, 32'hDEADBEEF, 64'h0});

        // Highest register index
        c = mk_cmd(WR, 3'd2, 8'd0);
        expect_resp(c, RWR, 2'b00, 64'd28, 64'h50, 32'h0);
        issue(c, 64'd28, 64'h50, 32'hCAFEF00D);
        c = mk_cmd(RD, 3'd2, 8'd0);
        expect_resp(c, RRD, 2'b00, 64'd28, 64'h51, 32'hCAFEF00D);
        issue(c, 64'd28, 64'h51, 32'h0);
        wait_drain();
        check("top_reg_q7", 256'(reg_q[255:224]), 256'(32'hCAFEF00D));

`ifdef UMI_REGFILE_POSTED_EN
        c = mk_cmd(PW, 3'd2, 8'd0);
        check("pw0_ready", 256'(umi_req_ready), 256'd1);
        issue(c, 64'd0, 64'h60, 32'h11111111);
        check("pw0_no_resp", 256'(umi_resp_valid), 256'd0);
        check("pw1_ready", 256'(umi_req_ready), 256'd1);
        issue(c, 64'd4, 64'h61, 32'h22222222);
        check("pw1_no_resp", 256'(umi_resp_valid), 256'd0);
        check("pw2_ready", 256'(umi_req_ready), 256'd1);
        issue(c, 64'd12, 64'h62, 32'h44444444);
        check("pw2_no_resp", 256'(umi_resp_valid), 256'd0);
        check("pw3_ready", 256'(umi_req_ready), 256'd1);
        issue(c, 64'd36, 64'h63, 32'h99999999);
        check("pw3_no_resp", 256'(umi_resp_valid), 256'd0);
        check("pw_reg_q", reg_q,
              {32'hCAFEF00D, 96'h0, 32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111});
`else
        c = mk_cmd(PW, 3'd2, 8'd0);
        expect_resp(c, RWR, 2'b11, 64'd12, 64'h60, 32'h0);
        issue(c, 64'd12, 64'h60, 32'h44444444);
        expect_resp(c, RWR, 2'b11, 64'd0, 64'h61, 32'h0);
        issue(c, 64'd0, 64'h61, 32'h11111111);
        wait_drain();
        check("pw_off_reg_q", reg_q, {32'hCAFEF00D, 128'h0, 32'hDEADBEEF, 64'h0});
`endif
        wait_drain();

        // Reset while a response is pending
        umi_resp_ready = 1'b0;
        c = mk_cmd(RD, 3'd2, 8'd0);
        issue(c, 64'd8, 64'h70, 32'h0);
        check("pend_valid", 256'(umi_resp_valid), 256'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", 256'(umi_resp_valid), 256'd0);
        check("rst_mid_reg_q", reg_q,                256'd0);
        check("rst_mid_ready", 256'(umi_req_ready),  256'd0);
        rst = 1'b0;
        umi_resp_ready = 1'b1;
        @(posedge clk); #1;
        expect_resp(c, RRD, 2'b00, 64'd8, 64'h71, 32'h0);
        issue(c, 64'd8, 64'h71, 32'h0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/umi_regfile.md
# umi_regfile

UMI request-consuming register endpoint that sits directly downstream of the simulation device interface and terminates its request stream. It decodes single-beat 32-bit read and write requests against a bank of NREGS control registers plus a read-only status word, and returns one UMI response per request. Register contents drive the FIR datapath configuration; status comes back from it.

## Interface
- DW, 256, UMI data width (≥32)
- AW, 64, UMI address width
- CW, 32, UMI command width (≥32)
- NREGS, 8, number of 32-bit read/write registers (2..64)
- BASE, 0, byte base address of register 0
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- umi_req_valid  input  1  request valid
- umi_req_cmd  input  CW  request command
- umi_req_dstaddr  input  AW  target byte address
- umi_req_srcaddr  input  AW  requester return address
- umi_req_data  input  DW  write data, bits [31:0] used
- umi_req_ready  output  1  request accepted when valid&ready
- umi_resp_valid  output  1  response valid
- umi_resp_cmd  output  CW  response command
- umi_resp_dstaddr  output  AW  = captured req srcaddr
- umi_resp_srcaddr  output  AW  = captured req dstaddr
- umi_resp_data  output  DW  read data zero-extended, 0 for writes/errors
- umi_resp_ready  input  1  response consumed when valid&ready
- reg_q  output  NREGS*32  register contents, reg i at [32*i+:32]
- status_i  input  32  status word, read-only at BASE+4*NREGS

## Operation
- cmd fields: opcode [4:0], size [7:5], len [15:8], err [26:25]; other bits copied to response unchanged.
- Request opcodes: READ 5'h01, WRITE 5'h03, POSTED 5'h05. Response opcodes: RESP_READ 5'h02, RESP_WRITE 5'h04.
- Legal access: size==3'd2, len==0, dstaddr[1:0]==0, BASE ≤ dstaddr, index=(dstaddr-BASE)>>2 ≤ NREGS (index NREGS = status).
- FSM: IDLE, RESP. IDLE: ready=1; on accept decode, perform write, load response regs, go RESP. RESP: ready=0, resp_valid=1; on resp_ready go IDLE.
- READ legal: data = reg[index] or status_i (sampled at accept cycle); RESP_READ, err=2'b00.
- WRITE legal, index<NREGS: reg[index] <= data[31:0]; RESP_WRITE, err=00.
- WRITE to status index: ignored, RESP_WRITE err=2'b10 (decode error).
- Illegal address/size/len: no register change; RESP_READ or RESP_WRITE per request opcode, err=2'b10, data 0.
- Unknown opcode: RESP_WRITE, err=2'b11, data 0, no register change.
- POSTED: see Configuration.

## Timing
- Reset: state IDLE, umi_req_ready 0 during rst, umi_resp_valid 0, resp cmd/addr/data 0, all reg_q 0.
- umi_req_ready = (state==IDLE) & ~rst; combinational from state only, never from umi_req_valid.
- Accept in cycle N -> umi_resp_valid=1 in cycle N+1; reg_q write visible in N+1.
- Response outputs stable while valid & ~ready. Back-to-back: resp handshake in cycle M -> next request acceptable M+1 (one bubble per transaction; peak 1 txn / 2 cycles).
- rst mid-transaction: pending response dropped, valid deasserted next cycle, registers cleared.

## Configuration
- UMI_REGFILE_POSTED_EN defined: POSTED performs write like WRITE but produces no response; FSM stays IDLE, next request acceptable N+1. Illegal posted writes silently dropped.
- Undefined: POSTED treated as unknown opcode (err=2'b11 response, no write).

## Structure
- Package umi_regfile_pkg: opcode localparams, field bit positions, err codes, size constant 3'd2, state enum.
- One sub-module umi_regfile_decode: combinational legality check and index computation from cmd/dstaddr.

## Test plan
- Reset, then WRITE 0xDEADBEEF to BASE+8 -> RESP_WRITE err=00 cycle N+1, reg_q[95:64]=0xDEADBEEF, resp dstaddr=req srcaddr.
- READ BASE+8 with umi_resp_ready held low 5 cycles -> RESP_READ data 0xDEADBEEF held stable, req_ready 0 throughout.
- status_i=0x12345678, READ BASE+4*NREGS -> data 0x12345678; WRITE same address -> err=10, status unaffected.
- READ BASE+2 (misaligned), READ with len=1, READ BASE+4*(NREGS+1) -> each err=10, data 0.
- With UMI_REGFILE_POSTED_EN: 4 back-to-back POSTED writes -> accepted on consecutive cycles, no resp_valid, registers updated; without macro -> err=11 responses.
- rst asserted while RESP pending -> resp_valid 0 next cycle, reg_q all 0, subsequent READ returns 0.
